ibex_rf_write_sched: RTL and testbench
======================================

// Module: ibex_rf_write_sched
// PURPOSE
//  Write-port scheduler for the FPGA register file. Shares the single regfile write port between
//  the core writeback path and an auxiliary requester (debug/external) with a starvation guard.
//  Runs an init sweep that writes WordZeroVal to every register 1..NUM_WORDS-1 after reset or
//  on request. Sits between ID/WB and ibex_register_file_fpga; drives waddr_a_i/wdata_a_i/we_a_i.
// PARAMETERS
//  RV32E        0     1: 16 registers (ADDR_WIDTH=4), else 32 (ADDR_WIDTH=5); NUM_WORDS=2**ADDR_WIDTH
//  DataWidth    32    register width
//  WordZeroVal  '0    value written by the init sweep
//  InitOnReset  1     1: sweep starts automatically when reset deasserts
//  StarveLimit  4     aux wait cycles (1..15) before aux is forced ahead of core
// PORTS
//  clk_i          in   1          clock
//  rst_i          in   1          synchronous reset, active-high
//  init_req_i     in   1          start init sweep (level, sampled in RUN)
//  init_busy_o    out  1          sweep in progress (state==SWEEP)
//  init_done_o    out  1          1-cycle pulse with the last sweep write
//  c_valid_i      in   1          core write request
//  c_ready_o      out  1          core request accepted when valid&ready
//  c_addr_i       in   5          core write address
//  c_data_i       in   DataWidth  core write data
//  a_valid_i      in   1          aux write request
//  a_ready_o      out  1          aux request accepted when valid&ready
//  a_addr_i       in   5          aux write address
//  a_data_i       in   DataWidth  aux write data
//  rf_we_o        out  1          regfile write enable (registered)
//  rf_waddr_o     out  5          regfile write address (registered)
//  rf_wdata_o     out  DataWidth  regfile write data (registered)
//  err_o          out  1          registered pulse: accepted write had addr >= NUM_WORDS
// BEHAVIOUR
//  - Reset: state=SWEEP if InitOnReset else RUN; sweep_cnt=1; starve_cnt=0; rf_we_o=0,
//    rf_waddr_o=0, rf_wdata_o=0, init_done_o=0, err_o=0. init_busy_o follows state.
//  - FSM SWEEP: both readys 0; each cycle register we=1, addr=sweep_cnt, data=WordZeroVal, then
//    sweep_cnt++. When sweep_cnt==NUM_WORDS-1: same edge sets init_done_o=1, state->RUN,
//    sweep_cnt->1. Sweep = NUM_WORDS-1 consecutive write cycles. init_req_i ignored in SWEEP.
//  - FSM RUN: init_req_i=1 -> both readys 0 that cycle, state->SWEEP, starve_cnt->0.
//  - Arbitration in RUN (init_req_i=0): force = a_valid_i && starve_cnt==StarveLimit.
//    a_ready_o = force || !c_valid_i; c_ready_o = !force. At most one accept per cycle.
//  - starve_cnt: +1 (saturating at StarveLimit) when a_valid_i && !a_ready_o; cleared on aux
//    accept, when a_valid_i=0, or entering SWEEP.
//  - Accepted write: next cycle rf_waddr_o/rf_wdata_o = request; rf_we_o = (addr!=0 && addr<NUM_WORDS).
//    addr==0 accepted and silently dropped. addr>=NUM_WORDS (RV32E only) dropped, err_o=1 one cycle.
//  - No accept and not SWEEP: rf_we_o=0; rf_waddr_o/rf_wdata_o hold last value.
//  - Latency: accept at edge N -> rf_we_o high in cycle N+1. Full throughput, 1 write/cycle.
//  - Reset mid-sweep: restart from reset values (sweep restarts at addr 1 if InitOnReset).
//  - Requesters must hold addr/data stable while valid && !ready.
// TESTING
//  1 InitOnReset=1, release rst_i -> rf_we_o=1 cycles 1..31, addr 1..31, data 0; init_done_o
//    with addr 31; readys 0 throughout; c_ready_o=1 next cycle.
//  2 c_valid_i&a_valid_i every cycle, StarveLimit=4 -> core wins 4 cycles, aux accepted 5th,
//    then core resumes; rf_waddr_o sequence matches grants with 1-cycle lag.
//  3 core writes addr 0 data 0xDEADBEEF -> accepted, rf_we_o stays 0, err_o 0.
//  4 RV32E=1, aux writes addr 16 -> accepted, rf_we_o 0, err_o pulses 1 cycle; addr 15 writes.
//  5 init_req_i during core traffic -> c_ready_o 0 that cycle, 15/31-write sweep follows,
//    pending core request accepted first cycle after init_done_o.
//  6 rst_i asserted at sweep addr 10 -> outputs to reset values; sweep restarts at addr 1.

Source files
------------

// File: rtl/ibex_rf_write_sched_if.sv
// Request bundle for the register-file write scheduler: core and auxiliary
// write requesters, each with a valid/ready handshake.
interface ibex_rf_write_sched_if #(
    parameter int DataWidth = 32
);
    logic                 c_valid_i;
    logic                 c_ready_o;
    logic [4:0]           c_addr_i;
    logic [DataWidth-1:0] c_data_i;
    logic                 a_valid_i;
    logic                 a_ready_o;
    logic [4:0]           a_addr_i;
    logic [DataWidth-1:0] a_data_i;

    // Handshake: a request transfers on a rising clock edge where valid && ready;
    // while valid && !ready the requester holds addr/data stable, and ready may
    // depend combinationally on valid.
    modport master (
        output c_valid_i, c_addr_i, c_data_i,
        output a_valid_i, a_addr_i, a_data_i,
        input  c_ready_o, a_ready_o
    );

    modport slave (
        input  c_valid_i, c_addr_i, c_data_i,
        input  a_valid_i, a_addr_i, a_data_i,
        output c_ready_o, a_ready_o
    );
endinterface

// File: rtl/ibex_rf_write_sched.sv
// Shares the single register-file write port between core writeback and an
// auxiliary requester, with a starvation guard and a zeroing init sweep.
module ibex_rf_write_sched #(
    parameter bit                   RV32E       = 1'b0,
    parameter int                   DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0,
    parameter bit                   InitOnReset = 1'b1,
    parameter int                   StarveLimit = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 init_req_i,
    output logic                 init_busy_o,
    output logic                 init_done_o,
    ibex_rf_write_sched_if.slave req_if,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 err_o
);
    localparam int             ADDR_WIDTH = RV32E ? 4 : 5;
    localparam int             NUM_WORDS  = 1 << ADDR_WIDTH;
    localparam logic [4:0]     LAST_ADDR  = 5'(NUM_WORDS - 1);
    localparam logic [5:0]     NW_LIMIT   = 6'(NUM_WORDS);
    localparam logic [3:0]     STARVE_LIM = 4'(StarveLimit);

    typedef enum logic {ST_RUN = 1'b0, ST_SWEEP = 1'b1} state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [4:0]           r_sweep_cnt;
    logic [3:0]           r_starve_cnt;
    logic                 r_rf_we;
    logic [4:0]           r_rf_waddr;
    logic [DataWidth-1:0] r_rf_wdata;
    logic                 r_init_done;
    logic                 r_err;

    logic                 w_force;
    logic                 w_c_ready;
    logic                 w_a_ready;
    logic                 w_c_acc;
    logic                 w_a_acc;
    logic                 w_acc;
    logic [4:0]           w_acc_addr;
    logic [DataWidth-1:0] w_acc_data;
    logic                 w_in_range;
    logic                 w_sweep_last;

    assign w_sweep_last = (r_sweep_cnt == LAST_ADDR);

    always_comb begin
        w_state_nxt = r_state;
        w_force     = 1'b0;
        w_c_ready   = 1'b0;
        w_a_ready   = 1'b0;
        w_c_acc     = 1'b0;
        w_a_acc     = 1'b0;
        w_acc       = 1'b0;
        w_acc_addr  = req_if.c_addr_i;
        w_acc_data  = req_if.c_data_i;
        case (r_state)
            ST_SWEEP: begin
                if (w_sweep_last) w_state_nxt = ST_RUN;
            end
            default: begin
                if (init_req_i) begin
                    w_state_nxt = ST_SWEEP;
                end else begin
                    // Aux jumps ahead only after waiting StarveLimit cycles.
                    w_force   = req_if.a_valid_i && (r_starve_cnt == STARVE_LIM);
                    w_a_ready = w_force || !req_if.c_valid_i;
                    w_c_ready = !w_force;
                    w_c_acc   = req_if.c_valid_i && w_c_ready;
                    w_a_acc   = req_if.a_valid_i && w_a_ready && !w_c_acc;
                    w_acc     = w_c_acc || w_a_acc;
                    if (w_a_acc) begin
                        w_acc_addr = req_if.a_addr_i;
                        w_acc_data = req_if.a_data_i;
                    end
                end
            end
        endcase
    end

    assign w_in_range = ({1'b0, w_acc_addr} < NW_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= InitOnReset ? ST_SWEEP : ST_RUN;
            r_sweep_cnt  <= 5'd1;
            r_starve_cnt <= 4'd0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= 5'd0;
            r_rf_wdata   <= '0;
            r_init_done  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rf_we     <= 1'b0;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
            if (r_state == ST_SWEEP) begin
                r_rf_we      <= 1'b1;
                r_rf_waddr   <= r_sweep_cnt;
                r_rf_wdata   <= WordZeroVal;
                r_starve_cnt <= 4'd0;
                if (w_sweep_last) begin
                    r_init_done <= 1'b1;
                    r_sweep_cnt <= 5'd1;
                end else begin
                    r_sweep_cnt <= r_sweep_cnt + 5'd1;
                end
            end else begin
                if (w_acc) begin
                    // Address 0 and out-of-range addresses are accepted but never written.
                    r_rf_waddr <= w_acc_addr;
                    r_rf_wdata <= w_acc_data;
                    r_rf_we    <= (w_acc_addr != 5'd0) && w_in_range;
                    r_err      <= !w_in_range;
                end
                if (init_req_i || !req_if.a_valid_i || w_a_acc) begin
                    r_starve_cnt <= 4'd0;
                end else if (r_starve_cnt != STARVE_LIM) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end
        end
    end

    assign req_if.c_ready_o = w_c_ready;
    assign req_if.a_ready_o = w_a_ready;
    assign init_busy_o      = (r_state == ST_SWEEP);
    assign init_done_o      = r_init_done;
    assign rf_we_o          = r_rf_we;
    assign rf_waddr_o       = r_rf_waddr;
    assign rf_wdata_o       = r_rf_wdata;
    assign err_o            = r_err;
endmodule

// File: tb/tb_ibex_rf_write_sched.sv
// Randomized scoreboard bench: a 32-register and a 16-register (RV32E) scheduler
// driven side by side, each checked against a transaction-level reference model.
module tb_ibex_rf_write_sched;
    localparam int LIMIT = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic init_req_i = 1'b0;

    always #5 clk_i = ~clk_i;

    logic        c_valid [2];
    logic [4:0]  c_addr  [2];
    logic [31:0] c_data  [2];
    logic        a_valid [2];
    logic [4:0]  a_addr  [2];
    logic [31:0] a_data  [2];
    logic        c_rdy   [2];
    logic        a_rdy   [2];
    logic        o_busy  [2];
    logic        o_done  [2];
    logic        o_we    [2];
    logic [4:0]  o_waddr [2];
    logic [31:0] o_wdata [2];
    logic        o_err   [2];

    ibex_rf_write_sched_if #(.DataWidth(32)) if0 ();
    ibex_rf_write_sched_if #(.DataWidth(32)) if1 ();

    assign if0.c_valid_i = c_valid[0];
    assign if0.c_addr_i  = c_addr[0];
    assign if0.c_data_i  = c_data[0];
    assign if0.a_valid_i = a_valid[0];
    assign if0.a_addr_i  = a_addr[0];
    assign if0.a_data_i  = a_data[0];
    assign c_rdy[0]      = if0.c_ready_o;
    assign a_rdy[0]      = if0.a_ready_o;
    assign if1.c_valid_i = c_valid[1];
    assign if1.c_addr_i  = c_addr[1];
    assign if1.c_data_i  = c_data[1];
    assign if1.a_valid_i = a_valid[1];
    assign if1.a_addr_i  = a_addr[1];
    assign if1.a_data_i  = a_data[1];
    assign c_rdy[1]      = if1.c_ready_o;
    assign a_rdy[1]      = if1.a_ready_o;

    ibex_rf_write_sched #(
        .RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'h0), .InitOnReset(1'b1), .StarveLimit(LIMIT)
    ) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .init_req_i(init_req_i),
        .init_busy_o(o_busy[0]), .init_done_o(o_done[0]), .req_if(if0),
        .rf_we_o(o_we[0]), .rf_waddr_o(o_waddr[0]), .rf_wdata_o(o_wdata[0]), .err_o(o_err[0])
    );

    ibex_rf_write_sched #(
        .RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0), .InitOnReset(1'b1), .StarveLimit(LIMIT)
    ) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .init_req_i(init_req_i),
        .init_busy_o(o_busy[1]), .init_done_o(o_done[1]), .req_if(if1),
        .rf_we_o(o_we[1]), .rf_waddr_o(o_waddr[1]), .rf_wdata_o(o_wdata[1]), .err_o(o_err[1])
    );

    int total = 0;
    int bad   = 0;

    // Expected observable write-port events: {we, err, done, addr[4:0], data[31:0]}.
    logic [39:0] exp_q0[$];
    logic [39:0] exp_q1[$];

    // Reference model state per instance.
    bit m_sweep [2];
    int m_next  [2];
    int m_wait  [2];
    int nw      [2];
    bit c_take  [2];
    bit a_take  [2];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input int d, input logic [39:0] item);
        if (d == 0) exp_q0.push_back(item);
        else        exp_q1.push_back(item);
    endtask

    // Monitor: every visible write-port event must match the oldest expected one.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            for (int d = 0; d < 2; d++) begin
                if (o_we[d] || o_err[d] || o_done[d]) begin
                    logic [39:0] got;
                    logic [39:0] exp;
                    int          sz;
                    got = {o_we[d], o_err[d], o_done[d], o_waddr[d], o_wdata[d]};
                    sz  = (d == 0) ? exp_q0.size() : exp_q1.size();
                    if (sz == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write dut%0d got=%0h exp=none t=%0t", d, got, $time);
                    end else begin
                        exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk($sformatf("wr_port_dut%0d", d), 64'(got), 64'(exp));
                    end
                end
            end
        end
    end

    // Accepted request: the reference decides write/drop/error from the address alone.
    task automatic emit(input int d, input logic [4:0] addr, input logic [31:0] data);
        bit we;
        bit err;
        err = (int'(addr) >= nw[d]);
        we  = (addr != 5'd0) && !err;
        if (we || err) push(d, {we, err, 1'b0, addr, data});
    endtask

    task automatic model_cycle(input int d);
        bit exp_c;
        bit exp_a;
        bit c_acc;
        bit a_acc;
        chk($sformatf("busy_dut%0d", d), 64'(o_busy[d]), 64'(m_sweep[d]));
        exp_c = 1'b0;
        exp_a = 1'b0;
        c_acc = 1'b0;
        a_acc = 1'b0;
        if (m_sweep[d]) begin
            push(d, {1'b1, 1'b0, (m_next[d] == nw[d] - 1), 5'(m_next[d]), 32'h0});
            if (m_next[d] == nw[d] - 1) begin
                m_sweep[d] = 1'b0;
                m_next[d]  = 1;
            end else begin
                m_next[d]++;
            end
            m_wait[d] = 0;
        end else if (init_req_i) begin
            m_sweep[d] = 1'b1;
            m_wait[d]  = 0;
        end else begin
            // Aux overtakes the core once it has waited LIMIT cycles in a row.
            exp_a = (a_valid[d] && m_wait[d] == LIMIT) || !c_valid[d];
            exp_c = !(a_valid[d] && m_wait[d] == LIMIT);
            c_acc = c_valid[d] && exp_c;
            a_acc = a_valid[d] && exp_a && !c_acc;
            if (c_acc) emit(d, c_addr[d], c_data[d]);
            if (a_acc) emit(d, a_addr[d], a_data[d]);
            if (a_valid[d] && !a_acc) m_wait[d] = (m_wait[d] < LIMIT) ? m_wait[d] + 1 : LIMIT;
            else                      m_wait[d] = 0;
        end
        chk($sformatf("c_ready_dut%0d", d), 64'(c_rdy[d]), 64'(exp_c));
        chk($sformatf("a_ready_dut%0d", d), 64'(a_rdy[d]), 64'(exp_a));
        c_take[d] = c_acc;
        a_take[d] = a_acc;
    endtask

    // One clock cycle; entered and left at negedge + 1.
    task automatic step(input int pc, input int pa, input bit ireq);
        for (int d = 0; d < 2; d++) begin
            if (!c_valid[d] && $urandom_range(99) < pc) begin
                c_valid[d] = 1'b1;
                c_addr[d]  = 5'($urandom_range(31));
                c_data[d]  = $urandom;
            end
            if (!a_valid[d] && $urandom_range(99) < pa) begin
                a_valid[d] = 1'b1;
                a_addr[d]  = 5'($urandom_range(31));
                a_data[d]  = $urandom;
            end
        end
        init_req_i = ireq;
        #1;
        model_cycle(0);
        model_cycle(1);
        @(posedge clk_i);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (c_take[d]) c_valid[d] = 1'b0;
            if (a_take[d]) a_valid[d] = 1'b0;
            c_take[d] = 1'b0;
            a_take[d] = 1'b0;
        end
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        init_req_i = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        for (int d = 0; d < 2; d++) begin
            c_valid[d] = 1'b0;
            a_valid[d] = 1'b0;
            c_take[d]  = 1'b0;
            a_take[d]  = 1'b0;
        end
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_we_dut%0d", d),    64'(o_we[d]),    64'd0);
            chk($sformatf("rst_waddr_dut%0d", d), 64'(o_waddr[d]), 64'd0);
            chk($sformatf("rst_wdata_dut%0d", d), 64'(o_wdata[d]), 64'd0);
            chk($sformatf("rst_err_dut%0d", d),   64'(o_err[d]),   64'd0);
            chk($sformatf("rst_done_dut%0d", d),  64'(o_done[d]),  64'd0);
            chk($sformatf("rst_busy_dut%0d", d),  64'(o_busy[d]),  64'd1);
            m_sweep[d] = 1'b1;
            m_next[d]  = 1;
            m_wait[d]  = 0;
        end
        rst_i = 1'b0;
    endtask

    task automatic put_core(input logic [4:0] addr, input logic [31:0] data);
        for (int d = 0; d < 2; d++) begin
            c_valid[d] = 1'b1;
            c_addr[d]  = addr;
            c_data[d]  = data;
        end
    endtask

    task automatic put_aux(input logic [4:0] addr, input logic [31:0] data);
        for (int d = 0; d < 2; d++) begin
            a_valid[d] = 1'b1;
            a_addr[d]  = addr;
            a_data[d]  = data;
        end
    endtask

    initial begin
        nw[0] = 32;
        nw[1] = 16;
        for (int d = 0; d < 2; d++) begin
            c_valid[d] = 1'b0; c_addr[d] = 5'd0; c_data[d] = 32'h0;
            a_valid[d] = 1'b0; a_addr[d] = 5'd0; a_data[d] = 32'h0;
        end
        @(negedge clk_i);
        #1;
        do_reset();

        // Power-on sweep, then idle.
        repeat (35) step(0, 0, 1'b0);

        // Both requesters saturated: starvation guard pattern.
        repeat (20) step(100, 100, 1'b0);
        repeat (6) step(0, 0, 1'b0);

        // Address 0 from core, then out-of-range and top-of-range from aux.
        put_core(5'd0, 32'hDEADBEEF);
        step(0, 0, 1'b0);
        put_aux(5'd16, 32'h1234_5678);
        step(0, 0, 1'b0);
        put_aux(5'd15, 32'hCAFE_F00D);
        step(0, 0, 1'b0);
        put_core(5'd31, 32'hA5A5_5A5A);
        step(0, 0, 1'b0);

        // Init request in the middle of core traffic.
        repeat (5) step(80, 50, 1'b0);
        step(80, 50, 1'b1);
        repeat (40) step(80, 50, 1'b0);

        // Random mix with occasional re-initialisation.
        for (int i = 0; i < 300; i++)
            step($urandom_range(100), $urandom_range(100), ($urandom_range(99) < 2));

        // Reset in the middle of a sweep.
        do_reset();
        for (int i = 0; i < 40 && m_next[0] != 10; i++) step(50, 50, 1'b0);
        do_reset();
        repeat (40) step(60, 60, 1'b0);

        repeat (40) step(0, 0, 1'b0);
        chk("q0_drained", 64'(exp_q0.size()), 64'd0);
        chk("q1_drained", 64'(exp_q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
